decoder_n_seq: RTL
==================

Name: decoder_n_seq

Overview:
- Registered, parametrised binary-to-one-hot decoder with N-bit select and 2**N outputs.
- Three run-time modes: level (hold), pulse (one-cycle strobe) and scan (free-running one-hot rotation, e.g. display digit or row strobing).
- Sits between control logic and strobe/select consumers. Replaces ad-hoc combinational decoders wherever a registered, glitch-free select is required.

Parameters:
- N, 3, select width; output width OUTS = 2**N (localparam, not overridable).
- SCAN_DIV, 4, clock cycles each one-hot position is held in scan mode; legal range 1..65535.
- DIV_W, 16, divider counter width; must satisfy SCAN_DIV <= 2**DIV_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- en  in  1  global enable; low forces outputs to zero.
- mode  in  2  00 = LEVEL, 01 = PULSE, 10 = SCAN, 11 = OFF.
- sel  in  N  binary select; sampled only on an accepted request.
- in_valid  in  1  sel qualifier.
- in_ready  out  1  high when a select can be accepted (en=1 and mode is LEVEL or PULSE); combinational from en/mode.
- out  out  OUTS  registered one-hot output, or all-zero.
- out_valid  out  1  registered; high exactly when out is non-zero.
- scan_idx  out  N  registered binary index of the current scan position; 0 outside SCAN.

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, scan_idx=0, divider=0, state=IDLE.
- Accept condition: in_valid && in_ready. out reflects an accepted sel exactly 1 cycle later; there is no combinational path from sel to out.
- FSM states IDLE, HOLD, PULSE, SCAN; out is a registered function of state and the latched index.
- IDLE (out=0):
  - LEVEL + accept -> HOLD.
  - PULSE + accept -> PULSE.
  - mode=SCAN && en -> SCAN.
- HOLD: out = onehot(latched sel).
  - A new accept re-latches sel and stays in HOLD.
  - Absence of in_valid keeps the value.
- PULSE: out = onehot(sel) for exactly 1 cycle.
  - Accept in the same cycle -> stay in PULSE with the new sel, so back-to-back pulses are legal and each request yields one cycle.
  - Otherwise -> IDLE.
- SCAN: out = onehot(scan_idx); sel and in_valid are ignored and in_ready=0.
  - Divider counts 0..SCAN_DIV-1. At terminal count: scan_idx increments modulo OUTS (wrap 2**N-1 -> 0) and divider returns to 0.
  - First SCAN cycle shows position 0 for a full SCAN_DIV cycles.
  - SCAN_DIV=1: position advances every cycle.
- Mode change (any change of mode while en=1): the next cycle is forced to IDLE with out=0, divider=0 and scan_idx=0. The one-cycle gap guarantees no two-hot overlap. An accept in the change cycle is dropped, because in_ready reflects the new mode only.
- en=0: in_ready=0. Next cycle forces IDLE, out=0, divider=0, scan_idx=0. When en re-asserts in SCAN, rotation restarts at position 0.
- mode=OFF: behaves as IDLE with in_ready=0.
- Reset asserted mid-scan or mid-pulse: outputs clear immediately (asynchronous); no residual pulse after release.
- Invariant: out is never more than one-hot (checked by assertion: $onehot0(out)).

Decomposition:
- Package decoder_pkg holds:
  - mode encodings MODE_LEVEL, MODE_PULSE, MODE_SCAN, MODE_OFF as a 2-bit typedef;
  - the FSM state typedef.
- Sub-module onehot_scan_ctr (parameters N, SCAN_DIV, DIV_W): contains the divider and the modulo-OUTS index with synchronous clear. Outputs are scan_idx and a step strobe.
- The one-hot conversion is a shared function in decoder_pkg.

Test Plan (N=3, SCAN_DIV=4 unless noted):
- Reset/level: release reset with en=1, mode=LEVEL, sel=5, in_valid=1 for 1 cycle -> out=0x00 on the first cycle after release, then 0x20 from the next cycle and held for 10 cycles with in_valid=0. out_valid=1 throughout the hold.
- Pulse back-to-back: mode=PULSE, in_valid=1 for 3 cycles with sel=0, 7, 3 -> out sequence 0x01, 0x80, 0x08, then 0x00. out_valid high for exactly 3 cycles.
- Scan wrap: mode=SCAN, en=1 for 40 cycles -> each of 0x01, 0x02 … 0x80 held 4 cycles, then 0x01 again at cycle 32. scan_idx tracks the position. Repeat with SCAN_DIV=1 -> position changes every cycle.
- Mode switch: in HOLD with out=0x04, switch mode to SCAN -> exactly one cycle of out=0x00, then 0x01 held for 4 cycles. An in_valid pulse in the switch cycle has no effect.
- Enable drop mid-scan: at scan_idx=5, set en=0 for 2 cycles -> out=0x00 and in_ready=0 during the drop. After en=1, scan restarts at 0x01.
- Async reset mid-pulse: assert rst_n=0 between clock edges while out=0x40 -> out=0x00 immediately. After release with in_valid=0, out stays 0x00; the $onehot0 assertion holds for the whole run.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and the one-hot helper for the registered binary-to-one-hot decoder.
package decoder_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL = 2'b00,
      MODE_PULSE = 2'b01,
      MODE_SCAN  = 2'b10,
      MODE_OFF   = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_HOLD  = 2'b01,
      ST_PULSE = 2'b10,
      ST_SCAN  = 2'b11
   } state_t;

   // One bit of a one-hot code: bit 'pos' is set only when it equals the binary index.
   function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
      return (idx == pos);
   endfunction

endpackage

// File: rtl/onehot_scan_ctr.sv
// Scan position generator: a SCAN_DIV-cycle divider and a modulo-2**N index.
module onehot_scan_ctr #(
   parameter int N        = 3,
   parameter int SCAN_DIV = 4,
   parameter int DIV_W    = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_run,
   output logic [N-1:0] o_scan_idx,
   output logic         o_step
);

   logic [DIV_W-1:0] r_div;
   logic [N-1:0]     r_idx;
   logic             w_term;

   assign w_term     = (r_div == DIV_W'(SCAN_DIV - 1));
   assign o_step     = i_run && !i_clr && w_term;
   assign o_scan_idx = r_idx;

   // The index wraps naturally because it is exactly N bits wide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (i_clr) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (i_run) begin
         if (w_term) begin
            r_div <= '0;
            r_idx <= r_idx + N'(1);
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered one-hot decoder with level, pulse and free-running scan modes.
module decoder_n_seq
   import decoder_pkg::*;
#(
   parameter int N        = 3,
   parameter int SCAN_DIV = 4,
   parameter int DIV_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [N-1:0]      sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [(1<<N)-1:0] out,
   output logic              out_valid,
   output logic [N-1:0]      scan_idx,
   output state_t            dbg_state
);

   localparam int OUTS = 1 << N;

   state_t          r_state;
   state_t          w_state_nxt;
   mode_t           r_mode_prev;
   logic [N-1:0]    r_sel_idx;
   logic [OUTS-1:0] r_out;
   logic            r_out_valid;

   logic            w_accept;
   logic            w_mode_chg;
   logic            w_scan_run;
   logic            w_step;
   logic [N-1:0]    w_scan_idx;
   logic [N-1:0]    w_scan_idx_nxt;
   logic [N-1:0]    w_out_idx;
   logic [OUTS-1:0] w_out_nxt;

   // Handshake: a select is taken on any rising edge where in_valid && in_ready;
   // in_ready depends only on en and the current mode, never on state.
   assign in_ready   = en && ((mode == MODE_LEVEL) || (mode == MODE_PULSE));
   assign w_accept   = in_valid && in_ready;
   assign w_mode_chg = (mode != r_mode_prev);

   always_comb begin
      w_state_nxt = r_state;
      if (!en || w_mode_chg) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (mode == MODE_SCAN) begin
                  w_state_nxt = ST_SCAN;
               end else if (w_accept) begin
                  w_state_nxt = (mode == MODE_LEVEL) ? ST_HOLD : ST_PULSE;
               end
            end
            ST_HOLD:  w_state_nxt = ST_HOLD;
            ST_PULSE: w_state_nxt = w_accept ? ST_PULSE : ST_IDLE;
            ST_SCAN:  w_state_nxt = ST_SCAN;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // The counter only advances while SCAN persists; any exit clears it to position 0.
   assign w_scan_run = (r_state == ST_SCAN) && (w_state_nxt == ST_SCAN);

   onehot_scan_ctr #(
      .N        (N),
      .SCAN_DIV (SCAN_DIV),
      .DIV_W    (DIV_W)
   ) u_scan_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (!w_scan_run),
      .i_run      (w_scan_run),
      .o_scan_idx (w_scan_idx),
      .o_step     (w_step)
   );

   always_comb begin
      w_scan_idx_nxt = '0;
      if (w_scan_run) begin
         w_scan_idx_nxt = w_step ? (w_scan_idx + N'(1)) : w_scan_idx;
      end
      w_out_idx = (w_state_nxt == ST_SCAN) ? w_scan_idx_nxt
                                           : (w_accept ? sel : r_sel_idx);
      w_out_nxt = '0;
      for (int i = 0; i < OUTS; i++) begin
         w_out_nxt[i] = (w_state_nxt != ST_IDLE) &&
                        onehot_bit(int'(unsigned'(w_out_idx)), i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mode_prev <= MODE_LEVEL;
         r_sel_idx   <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode_prev <= mode_t'(mode);
         if (w_accept) begin
            r_sel_idx <= sel;
         end
         r_out       <= w_out_nxt;
         r_out_valid <= (w_state_nxt != ST_IDLE);
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign scan_idx  = w_scan_idx;
   assign dbg_state = r_state;

endmodule
